// File: rtl/prio_enc_pkg.sv
// Shared sizing constants and a reusable highest-set-bit helper for the
// 8-to-3 priority encoder family.
package prio_enc_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = $clog2(IN_W);

  // Index of the highest set bit of v; returns 0 when v is all zeros, so
  // callers must qualify the result with |v.
  function automatic logic [OUT_W-1:0] highest_set(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (v[i]) idx = OUT_W'(i);
    end
    return idx;
  endfunction

endpackage : prio_enc_pkg

// File: rtl/priority_encoder_core.sv
// Combinational MSB-priority encoder: idx is the highest asserted bit of in,
// any is the OR-reduce of in.
module priority_encoder_core #(
  parameter int IN_W  = 8,
  parameter int OUT_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] idx,
  output logic             any
);

  always_comb begin
    // NOTE: defaults first so every path assigns idx/any and no latch is inferred.
    idx = '0;
    any = 1'b0;
    // Ascending scan: a later (higher) set bit overwrites earlier ones, so MSB wins.
    for (int i = 0; i < IN_W; i++) begin
      if (in[i]) begin
        idx = OUT_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule : priority_encoder_core

// File: rtl/priority_encoder_8to3.sv
// 8-input priority encoder with a one-cycle registered output stage and
// asynchronous active-low clear.
module priority_encoder_8to3
  import prio_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid
);

  logic [OUT_W-1:0] enc_idx;
  logic             enc_any;

  priority_encoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in  (in),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Outputs only move on a clock edge or on reset assertion, so downstream
  // logic never sees the combinational ripple of the encoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for registered state avoid simulation races.
      out   <= enc_idx;
      valid <= enc_any;
    end
  end

endmodule : priority_encoder_8to3

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench for priority_encoder_8to3: directed, walking-one,
// exhaustive and random stimulus against an arithmetic reference model.
module tb_priority_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic [2:0] out;
  logic       valid;

  int checks   = 0;
  int failures = 0;

  logic [7:0] prev;  // value present at the most recent rising edge

  priority_encoder_8to3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: floor(log2(v)) by repeated halving; 0 for v == 0.
  function automatic int ref_idx(input logic [7:0] v);
    int n;
    int k;
    n = int'(v);
    k = 0;
    while (n > 1) begin
      n = n / 2;
      k++;
    end
    return k;
  endfunction

  function automatic int ref_valid(input logic [7:0] v);
    return (v != 8'd0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive a new value just after an edge, then check that the outputs still
  // reflect the value captured at that edge, not the new combinational input.
  task automatic cycle(input logic [7:0] v, input string tag);
    @(posedge clk);
    #1;
    in = v;
    #1;
    check({tag, "_out"},   int'(out),   ref_idx(prev));
    check({tag, "_valid"}, int'(valid), ref_valid(prev));
    prev = v;
  endtask

  logic [7:0] pats [6] = '{8'b01010101, 8'b00010101, 8'b11010101,
                           8'b00110101, 8'b00000000, 8'b00000001};

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in    = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    check("reset_out",   int'(out),   0);
    check("reset_valid", int'(valid), 0);

    @(negedge clk);
    rst_n = 1'b1;
    prev  = in;

    foreach (pats[i]) cycle(pats[i], "pattern");

    for (int i = 0; i < 8; i++) begin
      logic [7:0] one;
      one = 8'd1 << i;
      cycle(one, "walk");
    end

    for (int v = 0; v < 256; v++) cycle(8'(v), "exhaustive");

    for (int n = 0; n < 200; n++) cycle(8'($urandom_range(0, 255)), "random");

    // Asynchronous reset mid-operation, asserted between edges.
    cycle(8'h80, "pre_async");
    cycle(8'h80, "pre_async");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out",   int'(out),   0);
    check("async_rst_valid", int'(valid), 0);
    @(posedge clk);
    #1;
    check("hold_rst_out",   int'(out),   0);
    check("hold_rst_valid", int'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev  = in;
    cycle(8'b00100110, "post_rst");
    cycle(8'b00000000, "post_rst");
    cycle(8'b00000000, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_priority_encoder_8to3
